// File: rtl/aes_kat_sequencer.sv
`timescale 1ns/1ps
// aes_kat_sequencer: replays key/plaintext vectors into an AES core,
// checks the ciphertext and keeps pass/fail/timeout statistics.
module aes_kat_sequencer #(
  parameter int DATA_W  = 128,
  parameter int NUM_VEC = 2,
  parameter int TIMEOUT = 64,
  parameter int GAP_CYC = 2,
  parameter bit LOOP    = 1'b0,
  parameter int CNT_W   = 16,
  parameter logic [NUM_VEC*DATA_W-1:0] KEY_ROM = {
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'h000102030405060708090a0b0c0d0e0f},
  parameter logic [NUM_VEC*DATA_W-1:0] PT_ROM = {
    128'h3243f6a8885a308d313198a2e0370734,
    128'h00112233445566778899aabbccddeeff},
  parameter logic [NUM_VEC*DATA_W-1:0] CT_ROM = {
    128'h3925841d02dc09fbdc118597196a0b32,
    128'h69c4e0d86a7b0430d8cdb78070b4c55a},
  localparam int VA_W = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              run,
  input  logic              abort,
  output logic              core_start,
  output logic [DATA_W-1:0] core_key,
  output logic [DATA_W-1:0] core_di,
  input  logic [DATA_W-1:0] core_do,
  input  logic              core_done,
  output logic              busy,
  output logic              finished,
  output logic [VA_W-1:0]   vec_idx,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              timeout_err,
  output logic [VA_W-1:0]   first_fail
);

  localparam int MAXC = (TIMEOUT > GAP_CYC) ? TIMEOUT : GAP_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_GAP, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] key_q, key_d;
  logic [DATA_W-1:0] di_q, di_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [VA_W-1:0]   vec_idx_q, vec_idx_d;
  logic [VA_W-1:0]   first_fail_q, first_fail_d;
  logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic              timeout_err_q, timeout_err_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic tmo, gap_ok, last;
  logic pass_inc, fail_inc;

  logic [DATA_W-1:0] key_rom [NUM_VEC];
  logic [DATA_W-1:0] pt_rom  [NUM_VEC];
  logic [DATA_W-1:0] ct_rom  [NUM_VEC];

  for (genvar i = 0; i < NUM_VEC; i++) begin : g_rom
    assign key_rom[i] = KEY_ROM[i*DATA_W +: DATA_W];
    assign pt_rom[i]  = PT_ROM[i*DATA_W +: DATA_W];
    assign ct_rom[i]  = CT_ROM[i*DATA_W +: DATA_W];
  end

  assign tmo    = (cnt_q == CW'(TIMEOUT - 1));
  assign gap_ok = (cnt_q >= CW'(GAP_CYC - 1)) && !core_done;
  assign last   = (vec_idx_q == VA_W'(NUM_VEC - 1));

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state: abort wins over done/timeout in every busy state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (run) state_d = S_LOAD;
      S_LOAD: state_d = abort ? S_DONE : S_RUN;
      S_RUN: begin
        if (abort)                 state_d = S_DONE;
        else if (core_done || tmo) state_d = S_GAP;
      end
      S_GAP: begin
        if (abort) state_d = S_DONE;
        else if (gap_ok)
          state_d = (last && !LOOP) ? S_DONE : S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    core_start = (state_q == S_RUN);
    busy       = (state_q == S_LOAD) || (state_q == S_RUN) ||
                 (state_q == S_GAP);
    finished   = (state_q == S_DONE);
  end

  // Datapath next values: vector load, scoring, gap/timeout counter
  always_comb begin
    key_d         = key_q;
    di_d          = di_q;
    exp_d         = exp_q;
    vec_idx_d     = vec_idx_q;
    first_fail_d  = first_fail_q;
    pass_cnt_d    = pass_cnt_q;
    fail_cnt_d    = fail_cnt_q;
    timeout_err_d = timeout_err_q;
    cnt_d         = cnt_q;
    pass_inc      = 1'b0;
    fail_inc      = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (run) begin
          vec_idx_d     = '0;
          first_fail_d  = '0;
          pass_cnt_d    = '0;
          fail_cnt_d    = '0;
          timeout_err_d = 1'b0;
        end
      end
      S_LOAD: begin
        key_d = key_rom[vec_idx_q];
        di_d  = pt_rom[vec_idx_q];
        exp_d = ct_rom[vec_idx_q];
        cnt_d = '0;
      end
      S_RUN: begin
        if (!abort) begin
          if (core_done) begin
            pass_inc = (core_do == exp_q);
            fail_inc = !pass_inc;
            cnt_d    = '0;
          end else if (tmo) begin
            fail_inc      = 1'b1;
            timeout_err_d = 1'b1;
            cnt_d         = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (cnt_q < CW'(GAP_CYC - 1)) cnt_d = cnt_q + 1'b1;
        if (!abort && gap_ok) begin
          if (!last)     vec_idx_d = vec_idx_q + 1'b1;
          else if (LOOP) vec_idx_d = '0;
        end
      end
      default: ;
    endcase
    if (pass_inc && (pass_cnt_q != '1))
      pass_cnt_d = pass_cnt_q + 1'b1;
    if (fail_inc) begin
      if (fail_cnt_q == '0) first_fail_d = vec_idx_q;
      if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      key_q         <= '0;
      di_q          <= '0;
      exp_q         <= '0;
      vec_idx_q     <= '0;
      first_fail_q  <= '0;
      pass_cnt_q    <= '0;
      fail_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      key_q         <= key_d;
      di_q          <= di_d;
      exp_q         <= exp_d;
      vec_idx_q     <= vec_idx_d;
      first_fail_q  <= first_fail_d;
      pass_cnt_q    <= pass_cnt_d;
      fail_cnt_q    <= fail_cnt_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign core_key    = key_q;
  assign core_di     = di_q;
  assign vec_idx     = vec_idx_q;
  assign pass_cnt    = pass_cnt_q;
  assign fail_cnt    = fail_cnt_q;
  assign timeout_err = timeout_err_q;
  assign first_fail  = first_fail_q;

endmodule

// File: tb/tb_aes_kat_sequencer.sv
`timescale 1ns/1ps
// tb_aes_kat_sequencer: two sequencers (LOOP=0 and LOOP=1 with 3-bit
// counters) driven by a behavioural AES core with configurable latency.
module tb_aes_kat_sequencer;

  localparam int TMO = 64;
  localparam int GAP = 2;
  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst [2];
  logic run [2];
  logic abort [2];
  bit   mon_clr [2];
  int   cfg_lat [2][2];
  bit   cfg_bad [2][2];
  bit   cfg_never [2];
  int   cfg_extra [2];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int CW = (g == 1) ? 3 : 16;
    logic          core_start, busy, finished, timeout_err;
    logic [127:0]  core_key, core_di;
    logic [127:0]  core_do = '0;
    logic          core_done = 1'b0;
    logic [0:0]    vec_idx, first_fail;
    logic [CW-1:0] pass_cnt, fail_cnt;
    logic          vsel;
    int            scnt = 0;
    int            hold_left = 0;
    int            nrise = 0;
    int            minlow = 1000;
    int            lowrun = 0;
    int            hi = 0;
    logic          prev_start = 1'b0;
    bit            bad = 1'b0;
    logic [127:0]  pkey = '0;

    assign vsel = (core_key == K1);

    aes_kat_sequencer #(
      .DATA_W(128), .NUM_VEC(2), .TIMEOUT(TMO), .GAP_CYC(GAP),
      .LOOP(g == 1), .CNT_W(CW),
      .KEY_ROM({K1, K0}), .PT_ROM({P1, P0}), .CT_ROM({C1, C0})
    ) u_dut (
      .CLK(clk), .RST(rst[g]), .run(run[g]), .abort(abort[g]),
      .core_start(core_start), .core_key(core_key),
      .core_di(core_di), .core_do(core_do), .core_done(core_done),
      .busy(busy), .finished(finished), .vec_idx(vec_idx),
      .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
      .timeout_err(timeout_err), .first_fail(first_fail)
    );

    // Core model: done appears cfg_lat cycles after start rises
    always @(negedge clk) begin
      if (core_done) begin
        if (hold_left == 0) core_done <= 1'b0;
        else hold_left <= hold_left - 1;
      end
      if (!core_start) scnt <= 0;
      else begin
        scnt <= scnt + 1;
        if (scnt == cfg_lat[g][vsel] - 1 && !cfg_never[g] && !core_done) begin
          core_done <= 1'b1;
          core_do   <= (vsel ? C1 : C0) ^ {127'b0, cfg_bad[g][vsel]};
          hold_left <= cfg_extra[g];
        end
      end
    end

    // Monitor: start edges, low gaps, high length, key stability
    always @(negedge clk) begin
      if (mon_clr[g]) begin
        nrise <= 0; minlow <= 1000; lowrun <= 0; hi <= 0;
        bad <= 1'b0; prev_start <= 1'b0;
      end else begin
        prev_start <= core_start;
        pkey <= core_key;
        if (core_start && !prev_start) begin
          nrise <= nrise + 1;
          hi <= 1;
          if (nrise > 0 && lowrun < minlow) minlow <= lowrun;
          if (core_done) bad <= 1'b1;
        end else if (core_start) begin
          hi <= hi + 1;
          if (core_key != pkey) bad <= 1'b1;
        end
        if (!core_start) lowrun <= prev_start ? 1 : lowrun + 1;
      end
    end
  end

  // Spec-level outcome: a vector passes iff done comes within TIMEOUT
  // cycles of start and carries the right ciphertext.
  task automatic ref_kat(input int l0, input int l1, input bit b0,
                         input bit b1, input bit nv, output int ep,
                         output int ef, output int et, output int eff);
    int lat [2];
    bit bd [2];
    bit t;
    lat[0] = l0; lat[1] = l1; bd[0] = b0; bd[1] = b1;
    ep = 0; ef = 0; et = 0; eff = 0;
    for (int i = 0; i < 2; i++) begin
      t = nv || (lat[i] > TMO);
      if (!t && !bd[i]) ep++;
      else begin
        if (ef == 0) eff = i;
        ef++;
        if (t) et = 1;
      end
    end
  endtask

  task automatic set_cfg0(input int l0, input int l1, input bit b0,
                          input bit b1, input bit nv, input int ex);
    cfg_lat[0][0] = l0; cfg_lat[0][1] = l1;
    cfg_bad[0][0] = b0; cfg_bad[0][1] = b1;
    cfg_never[0] = nv; cfg_extra[0] = ex;
  endtask

  task automatic do_kat0();
    bit fin;
    mon_clr[0] = 1'b1;
    @(negedge clk); #1 mon_clr[0] = 1'b0;
    run[0] = 1'b1;
    @(negedge clk); #1 run[0] = 1'b0;
    fin = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (inst[0].finished === 1'b1) begin fin = 1'b1; break; end
    end
    #1;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL kat_wait finished=0 required 1 within 3000 cycles");
    end
  endtask

  task automatic wait_rise1(input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (inst[1].nrise >= n) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_rise got %0d required %0d", inst[1].nrise, n);
    end
  endtask

  task automatic test_reset();
    rst[0] = 1'b1; rst[1] = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({inst[0].core_start, inst[0].busy, inst[0].finished,
         inst[0].vec_idx, inst[0].pass_cnt, inst[0].fail_cnt,
         inst[0].timeout_err, inst[0].first_fail, inst[0].core_key,
         inst[0].core_di} !== '0) begin
      errors++;
      $display("FAIL reset0 outputs nonzero key=%h pass=%0d",
               inst[0].core_key, inst[0].pass_cnt);
    end
    checks++;
    if ({inst[1].core_start, inst[1].busy, inst[1].finished,
         inst[1].vec_idx, inst[1].pass_cnt, inst[1].fail_cnt,
         inst[1].timeout_err, inst[1].first_fail, inst[1].core_key,
         inst[1].core_di} !== '0) begin
      errors++;
      $display("FAIL reset1 outputs nonzero key=%h pass=%0d",
               inst[1].core_key, inst[1].pass_cnt);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({inst[0].busy, inst[0].finished} !== 2'b00) begin
      errors++;
      $display("FAIL idle_hold busy/fin=%b required 00",
               {inst[0].busy, inst[0].finished});
    end
  endtask

  task automatic test_start_latency();
    set_cfg0(11, 11, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk); run[0] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({inst[0].core_start, inst[0].busy} !== 2'b01) begin
      errors++;
      $display("FAIL start_edge1 start/busy=%b required 01",
               {inst[0].core_start, inst[0].busy});
    end
    run[0] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({inst[0].core_start, inst[0].core_key, inst[0].core_di} !==
        {1'b1, K0, P0}) begin
      errors++;
      $display("FAIL start_edge2 start=%b key=%h di=%h",
               inst[0].core_start, inst[0].core_key, inst[0].core_di);
    end
    for (int i = 0; i < 500 && inst[0].finished !== 1'b1; i++)
      @(negedge clk);
    checks++;
    if (inst[0].pass_cnt !== 16'd2 || inst[0].finished !== 1'b1) begin
      errors++;
      $display("FAIL start_run pass=%0d fin=%b required 2/1",
               inst[0].pass_cnt, inst[0].finished);
    end
  endtask

  task automatic test_pass();
    int l0, l1, ep, ef, et, eff;
    for (int it = 0; it < 3; it++) begin
      l0 = (it == 0) ? 11 : $urandom_range(1, TMO);
      l1 = (it == 0) ? 11 : $urandom_range(1, TMO);
      set_cfg0(l0, l1, 1'b0, 1'b0, 1'b0, 0);
      ref_kat(l0, l1, 1'b0, 1'b0, 1'b0, ep, ef, et, eff);
      do_kat0();
      checks++;
      if (int'(inst[0].pass_cnt) != ep || int'(inst[0].fail_cnt) != ef) begin
        errors++;
        $display("FAIL pass%0d pass/fail=%0d/%0d required %0d/%0d lat=%0d,%0d",
                 it, inst[0].pass_cnt, inst[0].fail_cnt, ep, ef, l0, l1);
      end
      checks++;
      if (inst[0].nrise != 2 || inst[0].bad || inst[0].minlow < 2) begin
        errors++;
        $display("FAIL pass%0d_hs rises=%0d bad=%b minlow=%0d required 2/0/>=2",
                 it, inst[0].nrise, inst[0].bad, inst[0].minlow);
      end
    end
  endtask

  task automatic test_mismatch();
    int l0, l1, ep, ef, et, eff;
    bit b0, b1;
    for (int it = 0; it < 4; it++) begin
      l0 = (it == 0) ? 11 : $urandom_range(1, 70);
      l1 = (it == 0) ? 11 : $urandom_range(1, 70);
      b0 = (it == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      b1 = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      set_cfg0(l0, l1, b0, b1, 1'b0, 0);
      ref_kat(l0, l1, b0, b1, 1'b0, ep, ef, et, eff);
      do_kat0();
      checks++;
      if (int'(inst[0].pass_cnt) != ep || int'(inst[0].fail_cnt) != ef ||
          int'(inst[0].timeout_err) != et) begin
        errors++;
        $display("FAIL mis%0d p/f/t=%0d/%0d/%0d required %0d/%0d/%0d",
                 it, inst[0].pass_cnt, inst[0].fail_cnt,
                 inst[0].timeout_err, ep, ef, et);
      end
      if (ef != 0) begin
        checks++;
        if (int'(inst[0].first_fail) != eff) begin
          errors++;
          $display("FAIL mis%0d_ff got %0d required %0d",
                   it, inst[0].first_fail, eff);
        end
      end
    end
  endtask

  task automatic test_timeout();
    set_cfg0(11, 11, 1'b0, 1'b0, 1'b1, 0);
    do_kat0();
    checks++;
    if ({inst[0].pass_cnt, inst[0].fail_cnt, inst[0].timeout_err,
         inst[0].first_fail} !== {16'd0, 16'd2, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL tmo p/f/t/ff=%0d/%0d/%0d/%0d required 0/2/1/0",
               inst[0].pass_cnt, inst[0].fail_cnt, inst[0].timeout_err,
               inst[0].first_fail);
    end
    checks++;
    if (inst[0].hi != TMO || inst[0].nrise != 2) begin
      errors++;
      $display("FAIL tmo_len high=%0d rises=%0d required %0d/2",
               inst[0].hi, inst[0].nrise, TMO);
    end
  endtask

  task automatic test_timeout_edge();
    int ep, ef, et, eff;
    set_cfg0(TMO, TMO + 1, 1'b0, 1'b0, 1'b0, 0);
    ref_kat(TMO, TMO + 1, 1'b0, 1'b0, 1'b0, ep, ef, et, eff);
    do_kat0();
    checks++;
    if (int'(inst[0].pass_cnt) != ep || int'(inst[0].fail_cnt) != ef ||
        int'(inst[0].timeout_err) != et ||
        int'(inst[0].first_fail) != eff) begin
      errors++;
      $display("FAIL tmo_edge p/f/t/ff=%0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d",
               inst[0].pass_cnt, inst[0].fail_cnt, inst[0].timeout_err,
               inst[0].first_fail, ep, ef, et, eff);
    end
  endtask

  task automatic test_done_held();
    int l0, l1;
    l0 = $urandom_range(1, 30);
    l1 = $urandom_range(1, 30);
    set_cfg0(l0, l1, 1'b0, 1'b0, 1'b0, 5);
    do_kat0();
    checks++;
    if (inst[0].pass_cnt !== 16'd2 || inst[0].fail_cnt !== 16'd0 ||
        inst[0].nrise != 2) begin
      errors++;
      $display("FAIL held pass/fail/rises=%0d/%0d/%0d required 2/0/2",
               inst[0].pass_cnt, inst[0].fail_cnt, inst[0].nrise);
    end
    checks++;
    if (inst[0].bad || inst[0].minlow < 6) begin
      errors++;
      $display("FAIL held_gap bad=%b minlow=%0d required 0/>=6",
               inst[0].bad, inst[0].minlow);
    end
    cfg_extra[0] = 0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    set_cfg0($urandom_range(8, 30), $urandom_range(8, 30),
             1'b0, 1'b0, 1'b0, 0);
    @(negedge clk); run[0] = 1'b1;
    @(negedge clk); run[0] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (inst[0].vec_idx === 1'b1 && inst[0].core_start === 1'b1) begin
        ok = 1'b1; break;
      end
    end
    rst[0] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (!ok || {inst[0].core_start, inst[0].busy, inst[0].finished,
                inst[0].vec_idx, inst[0].pass_cnt, inst[0].fail_cnt,
                inst[0].timeout_err, inst[0].first_fail,
                inst[0].core_key, inst[0].core_di} !== '0) begin
      errors++;
      $display("FAIL rst_mid reached=%b start=%b pass=%0d key=%h",
               ok, inst[0].core_start, inst[0].pass_cnt, inst[0].core_key);
    end
    @(negedge clk); rst[0] = 1'b0;
    do_kat0();
    checks++;
    if (inst[0].pass_cnt !== 16'd2 || inst[0].fail_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_rerun pass/fail=%0d/%0d required 2/0",
               inst[0].pass_cnt, inst[0].fail_cnt);
    end
  endtask

  task automatic test_loop_abort();
    cfg_lat[1][0] = $urandom_range(3, 20);
    cfg_lat[1][1] = $urandom_range(3, 20);
    mon_clr[1] = 1'b1;
    @(negedge clk); #1 mon_clr[1] = 1'b0;
    run[1] = 1'b1;
    @(negedge clk); #1 run[1] = 1'b0;
    wait_rise1(7);
    abort[1] = 1'b1;
    @(posedge clk); #1;
    abort[1] = 1'b0;
    checks++;
    if ({inst[1].core_start, inst[1].finished, inst[1].busy} !== 3'b010) begin
      errors++;
      $display("FAIL abort_state start/fin/busy=%b required 010",
               {inst[1].core_start, inst[1].finished, inst[1].busy});
    end
    checks++;
    if (inst[1].pass_cnt !== 3'd6 || inst[1].fail_cnt !== 3'd0) begin
      errors++;
      $display("FAIL abort_cnt pass/fail=%0d/%0d required 6/0",
               inst[1].pass_cnt, inst[1].fail_cnt);
    end
  endtask

  task automatic test_saturate();
    mon_clr[1] = 1'b1;
    @(negedge clk); #1 mon_clr[1] = 1'b0;
    run[1] = 1'b1;
    @(negedge clk); #1 run[1] = 1'b0;
    wait_rise1(2);
    checks++;
    if (inst[1].pass_cnt !== 3'd1) begin
      errors++;
      $display("FAIL restart_clr pass=%0d required 1", inst[1].pass_cnt);
    end
    wait_rise1(11);
    abort[1] = 1'b1;
    @(posedge clk); #1;
    abort[1] = 1'b0;
    checks++;
    if (inst[1].pass_cnt !== 3'd7 || inst[1].fail_cnt !== 3'd0 ||
        inst[1].finished !== 1'b1) begin
      errors++;
      $display("FAIL saturate pass/fail/fin=%0d/%0d/%b required 7/0/1",
               inst[1].pass_cnt, inst[1].fail_cnt, inst[1].finished);
    end
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b1; run[g] = 1'b0; abort[g] = 1'b0; mon_clr[g] = 1'b0;
      cfg_lat[g][0] = 11; cfg_lat[g][1] = 11;
      cfg_bad[g][0] = 1'b0; cfg_bad[g][1] = 1'b0;
      cfg_never[g] = 1'b0; cfg_extra[g] = 0;
    end
    test_reset();
    test_start_latency();
    test_pass();
    test_mismatch();
    test_timeout();
    test_timeout_edge();
    test_done_held();
    test_reset_mid();
    test_loop_abort();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
